// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between a one-entry loader write buffer and
// two read ports (cassette, aux). The loader has fixed priority; the read ports share round-robin.
module sdram_port_arbiter #(
   parameter int ACCESS_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        ld_active,
   input  logic        ld_wr,
   input  logic [24:0] ld_addr,
   input  logic [7:0]  ld_data,
   output logic        ld_busy,
   output logic        ld_overrun,

   input  logic        cas_rd,
   input  logic [24:0] cas_addr,
   output logic [7:0]  cas_data,
   output logic        cas_valid,

   input  logic        aux_rd,
   input  logic [24:0] aux_addr,
   output logic [7:0]  aux_data,
   output logic        aux_valid,

   output logic [24:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_rd,
   output logic        mem_we,
   input  logic [7:0]  mem_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {GNT_LD, GNT_CAS, GNT_AUX} grant_t;

   localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t      state, state_next;
   grant_t      grant, grant_next;
   logic [3:0]  wait_cnt;
   logic        prefer_aux;
   logic        buf_full;
   logic [24:0] buf_addr;
   logic [7:0]  buf_data;

   logic        ld_req, cas_req, aux_req;
   logic        start, ld_clear, wait_last;

   // A write arriving in IDLE is granted directly so it is not overtaken by a
   // read requested in the same cycle; it still passes through the buffer.
   assign ld_req    = buf_full | ld_wr;
   assign cas_req   = cas_rd & ~ld_active;
   assign aux_req   = aux_rd & ~ld_active;
   assign start     = (state == IDLE) && (state_next == ISSUE);
   assign ld_clear  = (state == ISSUE) && (grant == GNT_LD);
   assign wait_last = (state == WAIT) && (wait_cnt == 4'd0);
   assign ld_busy   = buf_full;

   always_comb begin
      state_next = state;
      grant_next = grant;
      case (state)
         IDLE: begin
            if (ld_req) begin
               grant_next = GNT_LD;
               state_next = ISSUE;
            end else if (cas_req && aux_req) begin
               grant_next = prefer_aux ? GNT_AUX : GNT_CAS;
               state_next = ISSUE;
            end else if (cas_req) begin
               grant_next = GNT_CAS;
               state_next = ISSUE;
            end else if (aux_req) begin
               grant_next = GNT_AUX;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = WAIT;
         WAIT:    if (wait_cnt == 4'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes and valids are gated by reset so nothing escapes in a reset cycle.
   always_comb begin
      mem_we    = (state == ISSUE) && (grant == GNT_LD) && !reset;
      mem_rd    = (state == ISSUE) && (grant != GNT_LD) && !reset;
      cas_valid = (state == DONE) && (grant == GNT_CAS) && !reset;
      aux_valid = (state == DONE) && (grant == GNT_AUX) && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= GNT_LD;
         wait_cnt   <= 4'd0;
         prefer_aux <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         cas_data   <= '0;
         aux_data   <= '0;
      end else begin
         state <= state_next;
         grant <= grant_next;

         if (start) begin
            case (grant_next)
               GNT_LD: begin
                  mem_addr <= buf_full ? buf_addr : ld_addr;
                  mem_din  <= buf_full ? buf_data : ld_data;
               end
               GNT_CAS: mem_addr <= cas_addr;
               default: mem_addr <= aux_addr;
            endcase
            if (grant_next != GNT_LD)
               prefer_aux <= (grant_next == GNT_CAS);
         end

         if (state == ISSUE)
            wait_cnt <= WAIT_LOAD;
         else if (state == WAIT && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;

         if (wait_last && grant == GNT_CAS)
            cas_data <= mem_dout;
         if (wait_last && grant == GNT_AUX)
            aux_data <= mem_dout;
      end
   end

   // Loader buffer: a write in the emptying cycle refills it instead of overrunning.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full   <= 1'b0;
         buf_addr   <= '0;
         buf_data   <= '0;
         ld_overrun <= 1'b0;
      end else begin
         if (ld_wr && (!buf_full || ld_clear)) begin
            buf_full <= 1'b1;
            buf_addr <= ld_addr;
            buf_data <= ld_data;
         end else if (ld_clear) begin
            buf_full <= 1'b0;
         end
         if (ld_wr && buf_full && !ld_clear)
            ld_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter with ACCESS_CYCLES = 8;
// every expected cycle position below is counted from the edge that samples the request.
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_active, ld_wr;
   logic [24:0] ld_addr;
   logic [7:0]  ld_data;
   logic        ld_busy, ld_overrun;
   logic        cas_rd;
   logic [24:0] cas_addr;
   logic [7:0]  cas_data;
   logic        cas_valid;
   logic        aux_rd;
   logic [24:0] aux_addr;
   logic [7:0]  aux_data;
   logic        aux_valid;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_rd, mem_we;
   logic [7:0]  mem_dout;

   int tests  = 0;
   int failed = 0;
   int count;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.ACCESS_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_busy(ld_busy), .ld_overrun(ld_overrun),
      .cas_rd(cas_rd), .cas_addr(cas_addr), .cas_data(cas_data), .cas_valid(cas_valid),
      .aux_rd(aux_rd), .aux_addr(aux_addr), .aux_data(aux_data), .aux_valid(aux_valid),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_dout(mem_dout)
   );

   // Advance whole clocks; inputs change and outputs are sampled 1 ns after the edge.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      assert (observed === expected)
         else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1; ld_active = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
      cas_rd = 1'b0; cas_addr = '0; aux_rd = 1'b0; aux_addr = '0; mem_dout = '0;
      applyStimulus(2);
      checkOutput("rst_mem_rd", mem_rd, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_ld_busy", ld_busy, 0);
      checkOutput("rst_overrun", ld_overrun, 0);
      checkOutput("rst_cas_valid", cas_valid, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_cas_data", cas_data, 0);
      checkOutput("rst_aux_data", aux_data, 0);
      reset = 1'b0;
      applyStimulus(1);

      // Single cassette read: strobe one cycle after the request, valid at +10.
      cas_addr = 25'h0001234; mem_dout = 8'h5A; cas_rd = 1'b1;
      checkOutput("t1_no_early_rd", mem_rd, 0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1);
         checkOutput("t1_mem_rd", mem_rd, 32'(i == 1));
         checkOutput("t1_cas_valid", cas_valid, 32'(i == 10));
         if (i == 1) checkOutput("t1_mem_addr", mem_addr, 32'h0001234);
      end
      checkOutput("t1_addr_stable", mem_addr, 32'h0001234);
      checkOutput("t1_cas_data", cas_data, 32'h5A);
      cas_rd = 1'b0;
      applyStimulus(2);
      checkOutput("t1_no_repeat", mem_rd, 0);

      // Loader write and cassette read together: write first, read 11 cycles later.
      ld_wr = 1'b1; ld_addr = 25'h0000100; ld_data = 8'hC3;
      cas_rd = 1'b1; cas_addr = 25'h0002000; mem_dout = 8'h77;
      for (int i = 1; i <= 21; i++) begin
         applyStimulus(1);
         ld_wr = 1'b0;
         checkOutput("t2_mem_we", mem_we, 32'(i == 1));
         checkOutput("t2_mem_rd", mem_rd, 32'(i == 12));
         checkOutput("t2_cas_valid", cas_valid, 32'(i == 21));
         if (i == 1) begin
            checkOutput("t2_we_addr", mem_addr, 32'h0000100);
            checkOutput("t2_we_data", mem_din, 32'hC3);
            checkOutput("t2_busy_set", ld_busy, 1);
         end
         if (i == 2)  checkOutput("t2_busy_clear", ld_busy, 0);
         if (i == 12) checkOutput("t2_rd_addr", mem_addr, 32'h0002000);
      end
      checkOutput("t2_cas_data", cas_data, 32'h77);
      checkOutput("t2_no_overrun", ld_overrun, 0);
      cas_rd = 1'b0;
      applyStimulus(1);

      // Buffered write during a read, second write dropped as overrun.
      cas_rd = 1'b1; cas_addr = 25'h0000040; mem_dout = 8'h99;
      count = 0;
      for (int i = 1; i <= 22; i++) begin
         applyStimulus(1);
         ld_wr = 1'b0;
         if (i == 1) begin ld_wr = 1'b1; ld_addr = 25'h0000300; ld_data = 8'h11; end
         if (i == 2) begin
            checkOutput("t3_busy", ld_busy, 1);
            ld_wr = 1'b1; ld_addr = 25'h0000301; ld_data = 8'h22;
         end
         if (i == 3)  checkOutput("t3_overrun", ld_overrun, 1);
         if (i == 10) begin
            checkOutput("t3_cas_valid", cas_valid, 1);
            cas_rd = 1'b0;
         end
         if (i == 12) begin
            checkOutput("t3_we", mem_we, 1);
            checkOutput("t3_we_addr", mem_addr, 32'h0000300);
            checkOutput("t3_we_data", mem_din, 32'h11);
         end
         if (i == 13) checkOutput("t3_busy_clear", ld_busy, 0);
         if (mem_we) count++;
      end
      checkOutput("t3_we_count", count, 1);
      checkOutput("t3_overrun_sticky", ld_overrun, 1);
      reset = 1'b1;
      applyStimulus(1);
      reset = 1'b0;
      checkOutput("t3_overrun_reset", ld_overrun, 0);

      // Both read ports held: cas, aux, cas, aux, cassette first after reset.
      cas_rd = 1'b1; cas_addr = 25'h000000A; aux_rd = 1'b1; aux_addr = 25'h000000B;
      mem_dout = 8'h3C;
      for (int i = 1; i <= 43; i++) begin
         applyStimulus(1);
         checkOutput("t4_mem_rd", mem_rd, 32'(i == 1 || i == 12 || i == 23 || i == 34));
         checkOutput("t4_cas_valid", cas_valid, 32'(i == 10 || i == 32));
         checkOutput("t4_aux_valid", aux_valid, 32'(i == 21 || i == 43));
         if (i == 1 || i == 23) checkOutput("t4_cas_addr", mem_addr, 32'h000000A);
         if (i == 12 || i == 34) checkOutput("t4_aux_addr", mem_addr, 32'h000000B);
      end
      checkOutput("t4_aux_data", aux_data, 32'h3C);
      cas_rd = 1'b0; aux_rd = 1'b0;
      applyStimulus(2);
      checkOutput("t4_idle", mem_rd, 0);

      // Request withdrawn before any grant is cancelled.
      ld_active = 1'b1; cas_rd = 1'b1; cas_addr = 25'h0000555;
      applyStimulus(3);
      cas_rd = 1'b0; ld_active = 1'b0;
      count = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1);
         if (mem_rd) count++;
      end
      checkOutput("t5_cancel", count, 0);

      // ld_active holds an aux request for 50 cycles, then it is served.
      ld_active = 1'b1; aux_rd = 1'b1; aux_addr = 25'h0000055; mem_dout = 8'hE1;
      count = 0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1);
         if (mem_rd) count++;
      end
      checkOutput("t5_blocked", count, 0);
      ld_active = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1);
         checkOutput("t5_mem_rd", mem_rd, 32'(i == 1));
         checkOutput("t5_aux_valid", aux_valid, 32'(i == 10));
         if (i == 1) checkOutput("t5_addr", mem_addr, 32'h0000055);
      end
      checkOutput("t5_aux_data", aux_data, 32'hE1);
      aux_rd = 1'b0;
      applyStimulus(1);

      // Reset during the strobe cycle hides the strobe.
      cas_rd = 1'b1; cas_addr = 25'h0000077; mem_dout = 8'h12;
      applyStimulus(1);
      checkOutput("t6_strobe", mem_rd, 1);
      reset = 1'b1;
      #1;
      checkOutput("t6_strobe_suppressed", mem_rd, 0);
      applyStimulus(1);
      reset = 1'b0; cas_rd = 1'b0;
      checkOutput("t6_addr_reset", mem_addr, 0);
      applyStimulus(1);

      // Reset during WAIT aborts without a valid; a fresh read has nominal latency.
      cas_rd = 1'b1;
      applyStimulus(4);
      reset = 1'b1; cas_rd = 1'b0;
      applyStimulus(1);
      reset = 1'b0;
      checkOutput("t6_rd_reset", mem_rd, 0);
      checkOutput("t6_addr_wait_reset", mem_addr, 0);
      count = 0;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1);
         if (cas_valid || mem_rd) count++;
      end
      checkOutput("t6_no_valid", count, 0);
      checkOutput("t6_cas_data_reset", cas_data, 0);
      cas_rd = 1'b1; cas_addr = 25'h0000088; mem_dout = 8'h34;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1);
         checkOutput("t6_mem_rd", mem_rd, 32'(i == 1));
         checkOutput("t6_cas_valid", cas_valid, 32'(i == 10));
         if (i == 1) checkOutput("t6_addr", mem_addr, 32'h0000088);
      end
      checkOutput("t6_cas_data", cas_data, 32'h34);
      cas_rd = 1'b0;
      applyStimulus(2);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
